// File: rtl/eco_equiv_sweeper.sv
// Exhaustive on-chip equivalence sweeper for bitwise ECO netlists.
// Walks every (a,b) pair, samples y after a settle delay and checks it against NOR(a,b).
module eco_equiv_sweeper #(
   parameter int W        = 3,
   parameter int RESP_LAT = 0
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic           abort,
   output logic [W-1:0]   stim_a,
   output logic [W-1:0]   stim_b,
   input  logic [W-1:0]   resp_y,
   output logic           busy,
   output logic           done,
   output logic           pass,
   output logic [2*W:0]   mismatch_cnt,
   output logic [W-1:0]   first_fail_a,
   output logic [W-1:0]   first_fail_b,
   output logic [W-1:0]   first_fail_y,
   output logic           fail_seen
);

   localparam int VW = 2 * W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_WAIT,
      S_CHECK,
      S_DONE
   } state_e;

   state_e         state_q;
   logic [VW-1:0]  v_q;
   logic [VW-1:0]  v_d;
   logic [3:0]     wcnt_q;
   logic [VW:0]    cnt_q;
   logic [VW:0]    cnt_d;
   logic [W-1:0]   ffa_q;
   logic [W-1:0]   ffb_q;
   logic [W-1:0]   ffy_q;
   logic           fseen_q;
   logic [W-1:0]   y_exp;
   logic           miss;
   logic           last;

   assign v_d   = v_q + 1'b1;
   assign cnt_d = cnt_q + 1'b1;
   assign y_exp = ~(stim_a | stim_b);
   assign miss  = (resp_y != y_exp);
   assign last  = &v_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         v_q     <= '0;
         wcnt_q  <= '0;
         cnt_q   <= '0;
         ffa_q   <= '0;
         ffb_q   <= '0;
         ffy_q   <= '0;
         fseen_q <= 1'b0;
      end else if (abort) begin
         // Partial results stay visible for post-mortem until the next start.
         state_q <= S_IDLE;
         v_q     <= '0;
         wcnt_q  <= '0;
      end else begin
         unique case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_q <= S_DRIVE;
                  v_q     <= '0;
                  wcnt_q  <= '0;
                  cnt_q   <= '0;
                  ffa_q   <= '0;
                  ffb_q   <= '0;
                  ffy_q   <= '0;
                  fseen_q <= 1'b0;
               end
            end
            S_DRIVE: begin
               state_q <= (RESP_LAT > 0) ? S_WAIT : S_CHECK;
               wcnt_q  <= '0;
            end
            S_WAIT: begin
               if (wcnt_q == 4'(RESP_LAT - 1)) begin
                  state_q <= S_CHECK;
                  wcnt_q  <= '0;
               end else begin
                  wcnt_q <= wcnt_q + 1'b1;
               end
            end
            S_CHECK: begin
               if (miss) begin
                  cnt_q <= cnt_d;
                  if (!fseen_q) begin
                     ffa_q   <= stim_a;
                     ffb_q   <= stim_b;
                     ffy_q   <= resp_y;
                     fseen_q <= 1'b1;
                  end
               end
               if (last) begin
                  state_q <= S_DONE;
               end else begin
                  v_q     <= v_d;
                  state_q <= S_DRIVE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Stimulus comes straight from the vector index; a = upper half.
   assign stim_a       = v_q[VW-1:W];
   assign stim_b       = v_q[W-1:0];
   assign busy         = (state_q == S_DRIVE) || (state_q == S_WAIT) ||
                         (state_q == S_CHECK);
   assign done         = (state_q == S_DONE);
   assign pass         = done && (cnt_q == '0);
   assign mismatch_cnt = cnt_q;
   assign first_fail_a = ffa_q;
   assign first_fail_b = ffb_q;
   assign first_fail_y = ffy_q;
   assign fail_seen    = fseen_q;

endmodule
